byte_decode_stream: RTL

//  Streaming ByteDecode_d stage, directly downstream of the byte/bit packing stage (bytes2bits).
//  - Consumes N_BYTES-wide byte beats.
//  - Emits N_COEFFS unsigned d-bit coefficients, one per handshake, taken LSB-first from the bitstream.
//  - For d=12 every coefficient is reduced mod Q (FIPS 203 ByteDecode_12).
//  - Feeds the decompress / NTT input path.

---
 rtl/byte_decode_stream_pkg.sv | 29 ++
 rtl/byte_decode_stream_bytes2bits.sv | 28 ++
 rtl/byte_decode_stream.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/byte_decode_stream_pkg.sv
// -----------------------------------------------------------------------------
// byte_decode_stream_pkg
//   Shared definitions for the streaming ByteDecode_d stage:
//     - default modulus, polynomial length and widest coefficient width
//     - FSM state encoding
//     - single conditional subtraction used to reduce 12-bit coefficients
//   No ports (package).
// -----------------------------------------------------------------------------
package byte_decode_stream_pkg;

    // ML-KEM modulus; a 12-bit value is at most 4095 < 2*3329, so a single
    // conditional subtraction is a full reduction.
    localparam int DEF_Q        = 3329;
    localparam int DEF_N_COEFFS = 256;
    localparam int DEF_D_MAX    = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Returns v - q when v >= q, otherwise v. Sized generously so callers can
    // zero-extend any coefficient width up to 16 bits.
    function automatic logic [15:0] mod_q_once(input logic [15:0] v, input logic [15:0] q);
        return (v >= q) ? (v - q) : v;
    endfunction

endpackage

// File: rtl/byte_decode_stream_bytes2bits.sv
// -----------------------------------------------------------------------------
// bytes2bits
//   Flattens an N_BYTES-wide beat into a little-endian bitstream: bit k of
//   byte b becomes stream bit 8*b + k, so byte[0] bit 0 is the first bit of
//   the beat. The mapping is pure wiring; it exists as its own block so the
//   stream ordering is defined in exactly one place.
//
//   Ports:
//     i_bytes  in   N_BYTES*8  beat, byte[0] in bits [7:0]
//     o_bits   out  N_BYTES*8  bitstream, stream bit 0 in bit 0
// -----------------------------------------------------------------------------
module bytes2bits #(
    parameter int N_BYTES = 4
) (
    input  logic [N_BYTES*8-1:0] i_bytes,
    output logic [N_BYTES*8-1:0] o_bits
);

    always_comb begin
        o_bits = '0;
        for (int b = 0; b < N_BYTES; b++) begin
            for (int k = 0; k < 8; k++) begin
                o_bits[8*b + k] = i_bytes[8*b + k];
            end
        end
    end

endmodule

// File: rtl/byte_decode_stream.sv
// -----------------------------------------------------------------------------
// byte_decode_stream
//   Streaming ByteDecode_d. Accepts byte beats, appends them to a bit
//   accumulator and emits N_COEFFS unsigned d-bit coefficients, LSB-first
//   from the stream. For d == D_MAX (12) each coefficient is reduced mod Q.
//
//   Ports:
//     clk_i        in   1          clock, rising edge
//     rst_i        in   1          asynchronous active-high reset
//     start_i      in   1          begin one polynomial (honoured only in IDLE)
//     d_i          in   4          coefficient width 1..D_MAX, latched on start
//     bytes_i      in   N_BYTES*8  input beat, byte[0] = lowest stream bits
//     in_valid_i   in   1          input beat valid
//     in_ready_o   out  1          beat can be accepted this cycle
//     coeff_o      out  D_MAX      decoded coefficient, zero-extended
//     out_valid_o  out  1          coeff_o valid
//     out_ready_i  in   1          downstream accepts coeff_o
//     last_o       out  1          marks coefficient N_COEFFS-1
//     done_o       out  1          one-cycle pulse after the last coefficient
// -----------------------------------------------------------------------------
module byte_decode_stream
    import byte_decode_stream_pkg::*;
#(
    parameter int N_BYTES  = 4,
    parameter int D_MAX    = DEF_D_MAX,
    parameter int N_COEFFS = DEF_N_COEFFS,
    parameter int Q        = DEF_Q
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [3:0]           d_i,
    input  logic [N_BYTES*8-1:0] bytes_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    output logic [D_MAX-1:0]     coeff_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic                 last_o,
    output logic                 done_o
);

    localparam int BEAT_W  = N_BYTES * 8;
    // Holds up to d-1 leftover bits plus one full beat.
    localparam int ACC_W   = D_MAX - 1 + BEAT_W;
    localparam int FILL_W  = $clog2(ACC_W + 1);
    localparam int NB_LOG2 = $clog2(N_BYTES);
    localparam int BEATS_W = $clog2(32 * D_MAX / N_BYTES + 1);
    localparam int CNT_W   = $clog2(N_COEFFS);

    localparam logic [3:0]       D_MAX_L  = 4'(D_MAX);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_COEFFS - 1);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t               r_state;
    logic [3:0]           r_d;
    logic [ACC_W-1:0]     r_acc;
    logic [FILL_W-1:0]    r_fill;
    logic [BEATS_W-1:0]   r_beat_cnt;
    logic [CNT_W-1:0]     r_coeff_cnt;

    // ------------------------------------------------------------------
    // Combinational nets
    // ------------------------------------------------------------------
    state_t               w_state_nxt;
    logic                 w_start_ok;
    logic [BEAT_W-1:0]    w_bits;
    logic [BEATS_W-1:0]   w_beats_total;
    logic [FILL_W-1:0]    w_d_fill;
    logic [FILL_W:0]      w_fill_sum;
    logic                 w_room;
    logic                 w_in_fire;
    logic                 w_out_fire;
    logic                 w_last_fire;
    logic [ACC_W-1:0]     w_acc_base;
    logic [ACC_W-1:0]     w_beat_ext;
    logic [ACC_W-1:0]     w_acc_nxt;
    logic [FILL_W-1:0]    w_pos;
    logic [FILL_W-1:0]    w_fill_nxt;
    logic [D_MAX-1:0]     w_mask;
    logic [D_MAX-1:0]     w_raw;

    bytes2bits #(
        .N_BYTES (N_BYTES)
    ) u_bytes2bits (
        .i_bytes (bytes_i),
        .o_bits  (w_bits)
    );

    // A start is taken only from IDLE and only with a legal width; anything
    // else leaves the block idle so a bad d can never produce coefficients.
    assign w_start_ok = (r_state == IDLE) && start_i &&
                        (d_i != 4'd0) && (d_i <= D_MAX_L);

    // One polynomial is exactly N_COEFFS*d bits = 32*d bytes (N_COEFFS=256),
    // i.e. 32*d/N_BYTES beats. N_BYTES is a power of two, so divide by shift.
    assign w_beats_total = BEATS_W'((16'(r_d) << 5) >> NB_LOG2);

    assign w_d_fill   = FILL_W'(r_d);
    // Extra bit keeps the room check from wrapping.
    assign w_fill_sum = {1'b0, r_fill} + (FILL_W + 1)'(BEAT_W);
    assign w_room     = (w_fill_sum <= (FILL_W + 1)'(ACC_W));

    // ------------------------------------------------------------------
    // FSM next state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        last_o      = 1'b0;
        done_o      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start_ok) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                in_ready_o  = (r_beat_cnt < w_beats_total) && w_room;
                out_valid_o = (r_fill >= w_d_fill);
                last_o      = out_valid_o && (r_coeff_cnt == LAST_IDX);
                if (out_valid_o && out_ready_i && last_o) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                done_o      = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign w_in_fire   = in_valid_i && in_ready_o;
    assign w_out_fire  = out_valid_o && out_ready_i;
    assign w_last_fire = w_out_fire && last_o;

    // ------------------------------------------------------------------
    // Accumulator update
    //   Output transfer consumes d bits from the bottom; an incoming beat is
    //   appended just above the bits that remain, so with a simultaneous
    //   transfer it lands at fill - d. in_ready guarantees fill <= ACC_W -
    //   BEAT_W, so the shifted beat never spills past the top.
    //   Bits above fill are always zero, so OR-in is safe.
    // ------------------------------------------------------------------
    assign w_acc_base = w_out_fire ? (r_acc >> r_d) : r_acc;
    assign w_pos      = w_out_fire ? (r_fill - w_d_fill) : r_fill;
    assign w_beat_ext = {{(ACC_W - BEAT_W){1'b0}}, w_bits};
    assign w_acc_nxt  = w_in_fire ? (w_acc_base | (w_beat_ext << w_pos)) : w_acc_base;
    assign w_fill_nxt = w_pos + (w_in_fire ? FILL_W'(BEAT_W) : {FILL_W{1'b0}});

    // ------------------------------------------------------------------
    // Coefficient extraction
    //   For d == D_MAX the raw value is at most 4095, so one subtraction of
    //   Q suffices. Narrower widths are passed through unreduced.
    // ------------------------------------------------------------------
    assign w_mask  = ~({D_MAX{1'b1}} << r_d);
    assign w_raw   = r_acc[D_MAX-1:0] & w_mask;
    assign coeff_o = (r_d == D_MAX_L) ? D_MAX'(mod_q_once(16'(w_raw), 16'(Q))) : w_raw;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    //   Outside RUN (and on the final transfer) the accumulator and counters
    //   are cleared, so any leftover bits from a malformed stream are dropped
    //   and coeff_o reads 0 while idle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_d         <= 4'd0;
            r_acc       <= '0;
            r_fill      <= '0;
            r_beat_cnt  <= '0;
            r_coeff_cnt <= '0;
        end else begin
            if (w_start_ok) begin
                r_d <= d_i;
            end
            if ((r_state == RUN) && !w_last_fire) begin
                r_acc       <= w_acc_nxt;
                r_fill      <= w_fill_nxt;
                r_beat_cnt  <= r_beat_cnt + {{(BEATS_W-1){1'b0}}, w_in_fire};
                r_coeff_cnt <= r_coeff_cnt + {{(CNT_W-1){1'b0}}, w_out_fire};
            end else begin
                r_acc       <= '0;
                r_fill      <= '0;
                r_beat_cnt  <= '0;
                r_coeff_cnt <= '0;
            end
        end
    end

endmodule
